// File: rtl/pad_cfg_ctrl_pkg.sv
// Shared types for the pad configuration controller: per-pad config struct,
// bit positions inside cfg_data, reset value and apply-sequencer states.
package pad_cfg_pkg;

  typedef struct packed {
    logic oe;
    logic cs;
    logic sl;
    logic ie;
    logic pu;
    logic pd;
  } pad_cfg_t;

  localparam int unsigned BIT_OE = 5;
  localparam int unsigned BIT_CS = 4;
  localparam int unsigned BIT_SL = 3;
  localparam int unsigned BIT_IE = 2;
  localparam int unsigned BIT_PU = 1;
  localparam int unsigned BIT_PD = 0;

  // Safe idle pad: driver off, input buffer enabled, no pulls.
  localparam pad_cfg_t PAD_CFG_RST = '{oe: 1'b0, cs: 1'b0, sl: 1'b0, ie: 1'b1, pu: 1'b0, pd: 1'b0};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OE_OFF = 3'd1,
    ST_WAIT1  = 3'd2,
    ST_UPDATE = 3'd3,
    ST_WAIT2  = 3'd4,
    ST_OE_ON  = 3'd5,
    ST_DONE   = 3'd6
  } fsm_state_e;

endpackage

// File: rtl/pad_cfg_ctrl_if.sv
// Bus bundle for pad_cfg_ctrl: config write channel, apply control, pad bus
// and FSM debug state. PAD_CFG_READBACK_EN adds the rd_idx/rd_data port pair.
interface pad_cfg_ctrl_if #(
  parameter int NUM_BIDIR_PADS = 40
) ();
  import pad_cfg_pkg::*;

  // Write channel: a write is accepted on any edge where cfg_valid && cfg_ready.
  // The controller only raises cfg_ready while idle, and cfg_valid may be held
  // or dropped freely while cfg_ready is low.
  logic       cfg_valid;
  logic       cfg_ready;
  logic [5:0] cfg_idx;
  logic [5:0] cfg_data;
  logic       cfg_err;

  logic       apply_req;
  logic       apply_busy;
  logic       apply_done;

  logic [NUM_BIDIR_PADS-1:0] bidir_oe;
  logic [NUM_BIDIR_PADS-1:0] bidir_cs;
  logic [NUM_BIDIR_PADS-1:0] bidir_sl;
  logic [NUM_BIDIR_PADS-1:0] bidir_ie;
  logic [NUM_BIDIR_PADS-1:0] bidir_pu;
  logic [NUM_BIDIR_PADS-1:0] bidir_pd;

  fsm_state_e dbg_state;

`ifdef PAD_CFG_READBACK_EN
  logic [5:0] rd_idx;
  logic [5:0] rd_data;
`endif

  modport master (
    output cfg_valid, cfg_idx, cfg_data, apply_req,
    input  cfg_ready, cfg_err, apply_busy, apply_done,
    input  bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd,
    input  dbg_state
`ifdef PAD_CFG_READBACK_EN
    , output rd_idx
    , input  rd_data
`endif
  );

  modport slave (
    input  cfg_valid, cfg_idx, cfg_data, apply_req,
    output cfg_ready, cfg_err, apply_busy, apply_done,
    output bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd,
    output dbg_state
`ifdef PAD_CFG_READBACK_EN
    , input  rd_idx
    , output rd_data
`endif
  );

endinterface

// File: rtl/pad_cfg_ctrl.sv
// Pad configuration controller: shadow/active per-pad config with a glitch-safe
// apply sequence. Optional readback port enabled by PAD_CFG_READBACK_EN.
module pad_cfg_ctrl
  import pad_cfg_pkg::*;
#(
  parameter int NUM_BIDIR_PADS = 40,
  parameter int SETTLE_CYCLES  = 4
) (
  input logic           clk,
  input logic           rst,
  pad_cfg_ctrl_if.slave bus
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  fsm_state_e state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       cfg_err_q, cfg_err_d;

  pad_cfg_t shadow_q [NUM_BIDIR_PADS];
  pad_cfg_t shadow_d [NUM_BIDIR_PADS];
  pad_cfg_t active_q [NUM_BIDIR_PADS];
  pad_cfg_t active_d [NUM_BIDIR_PADS];

  logic wr_accept;
  logic wr_in_range;

  assign wr_accept   = bus.cfg_valid && (state_q == ST_IDLE);
  assign wr_in_range = 32'(bus.cfg_idx) < NUM_BIDIR_PADS;
  assign cfg_err_d   = wr_accept && !wr_in_range;

  // Sequencer; each WAIT state lasts SETTLE_CYCLES cycles (counter loaded with N-1).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.apply_req) state_d = ST_OE_OFF;
      end
      ST_OE_OFF: begin
        state_d = ST_WAIT1;
        cnt_d   = SETTLE_LOAD;
      end
      ST_WAIT1: begin
        if (cnt_q == 8'd0) state_d = ST_UPDATE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_UPDATE: begin
        state_d = ST_WAIT2;
        cnt_d   = SETTLE_LOAD;
      end
      ST_WAIT2: begin
        if (cnt_q == 8'd0) state_d = ST_OE_ON;
        else               cnt_d   = cnt_q - 8'd1;
      end
      ST_OE_ON: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shadow takes writes in IDLE; active changes only in the three apply phases.
  always_comb begin
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      shadow_d[i] = shadow_q[i];
      active_d[i] = active_q[i];
      if (wr_accept && (32'(bus.cfg_idx) == i)) shadow_d[i] = pad_cfg_t'(bus.cfg_data);
      unique case (state_q)
        ST_OE_OFF: begin
          if (shadow_q[i] != active_q[i]) active_d[i].oe = 1'b0;
        end
        ST_UPDATE: begin
          active_d[i].cs = shadow_q[i].cs;
          active_d[i].sl = shadow_q[i].sl;
          active_d[i].ie = shadow_q[i].ie;
          active_d[i].pu = shadow_q[i].pu;
          // Pull-up wins so the pad never fights both pulls.
          active_d[i].pd = shadow_q[i].pd & ~shadow_q[i].pu;
        end
        ST_OE_ON: begin
          active_d[i].oe = shadow_q[i].oe;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
      for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
        shadow_q[i] <= PAD_CFG_RST;
        active_q[i] <= PAD_CFG_RST;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cfg_err_q <= cfg_err_d;
      for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
        shadow_q[i] <= shadow_d[i];
        active_q[i] <= active_d[i];
      end
    end
  end

  logic [NUM_BIDIR_PADS-1:0] oe_vec, cs_vec, sl_vec, ie_vec, pu_vec, pd_vec;

  always_comb begin
    oe_vec = '0;
    cs_vec = '0;
    sl_vec = '0;
    ie_vec = '0;
    pu_vec = '0;
    pd_vec = '0;
    for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
      oe_vec[i] = active_q[i][BIT_OE];
      cs_vec[i] = active_q[i][BIT_CS];
      sl_vec[i] = active_q[i][BIT_SL];
      ie_vec[i] = active_q[i][BIT_IE];
      pu_vec[i] = active_q[i][BIT_PU];
      pd_vec[i] = active_q[i][BIT_PD];
    end
  end

  assign bus.bidir_oe   = oe_vec;
  assign bus.bidir_cs   = cs_vec;
  assign bus.bidir_sl   = sl_vec;
  assign bus.bidir_ie   = ie_vec;
  assign bus.bidir_pu   = pu_vec;
  assign bus.bidir_pd   = pd_vec;

  assign bus.cfg_ready  = (state_q == ST_IDLE);
  assign bus.cfg_err    = cfg_err_q;
  assign bus.apply_busy = (state_q != ST_IDLE);
  assign bus.apply_done = (state_q == ST_DONE);
  assign bus.dbg_state  = state_q;

`ifdef PAD_CFG_READBACK_EN
  logic [5:0] rd_data_q;

  // Out-of-range indices fall through to the zero default.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= '0;
      for (int i = 0; i < NUM_BIDIR_PADS; i++) begin
        if (32'(bus.rd_idx) == i) rd_data_q <= active_q[i];
      end
    end
  end

  assign bus.rd_data = rd_data_q;
`endif

endmodule

// File: doc/pad_cfg_ctrl.md
PAD_CFG_CTRL -- requirements
Module: pad_cfg_ctrl

Interface
REQ-001 SHALL have parameter NUM_BIDIR_PADS, default 40, meaning the number of bidirectional pads controlled.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4, meaning the wait in cycles after each apply phase (legal range 1..255).
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port cfg_valid, input, 1: write request.
REQ-006 SHALL have port cfg_ready, output, 1: write accepted when valid&&ready.
REQ-007 SHALL have port cfg_idx, input, 6: target pad index.
REQ-008 SHALL have port cfg_data, input, 6: {oe,cs,sl,ie,pu,pd}, bit5..bit0.
REQ-009 SHALL have port cfg_err, output, 1: one-cycle pulse on an accepted write with cfg_idx>=NUM_BIDIR_PADS.
REQ-010 SHALL have port apply_req, input, 1: start apply sequence.
REQ-011 SHALL have port apply_busy, output, 1: apply sequence in progress.
REQ-012 SHALL have port apply_done, output, 1: one-cycle pulse at end of apply.
REQ-013 SHALL have ports bidir_oe, bidir_cs, bidir_sl, bidir_ie, bidir_pu, bidir_pd, each output, NUM_BIDIR_PADS: active per-pad controls to the core pad bus.

Function
REQ-014 SHALL hold a shadow configuration per pad (6 bits) and an active configuration driving the outputs.
REQ-015 SHALL assert cfg_ready only in IDLE; an accepted in-range write updates that pad's shadow entry at the next edge.
REQ-016 SHALL discard out-of-range writes (no shadow change) and pulse cfg_err the cycle after acceptance.
REQ-017 SHALL run FSM IDLE -> OE_OFF -> WAIT1 -> UPDATE -> WAIT2 -> OE_ON -> DONE -> IDLE; apply_req is sampled only in IDLE.
REQ-018 OE_OFF (1 cycle): clear bidir_oe for every pad whose shadow differs from active in any bit; unchanged pads keep OE.
REQ-019 WAIT1/WAIT2: remain exactly SETTLE_CYCLES cycles each using an 8-bit down-counter.
REQ-020 UPDATE (1 cycle): copy cs, sl, ie, pu, pd from shadow to active for all pads.
REQ-021 OE_ON (1 cycle): copy oe from shadow to active for all pads.
REQ-022 DONE (1 cycle): apply_done=1; next state IDLE.
REQ-023 apply_busy SHALL be 1 in every state except IDLE; apply_req latency to bidir_oe drop is 1 cycle; total apply is 4+2*SETTLE_CYCLES cycles from the apply_req edge to the return to IDLE.
REQ-024 Simultaneous cfg_valid&&cfg_ready and apply_req in IDLE: the write SHALL be included in the apply.
REQ-025 apply_req while busy SHALL be ignored (not queued).
REQ-026 An apply with shadow==active SHALL still run the full sequence without any output toggling.
REQ-027 bidir_pu and bidir_pd SHALL never be simultaneously 1 on a pad: when a shadow entry has pu=pd=1, UPDATE SHALL apply pd=0.

Reset
REQ-028 On rst, both shadow and active SHALL become oe=0, cs=0, sl=0, ie=1, pu=0, pd=0 for all pads.
REQ-029 On rst, the FSM SHALL enter IDLE, the counter SHALL clear, and cfg_err=0, apply_done=0, apply_busy=0, cfg_ready=1 after the edge.
REQ-030 rst mid-apply SHALL abort the apply with no DONE pulse and apply the reset values at that edge.

Configuration
REQ-031 Macro PAD_CFG_READBACK_EN SHALL, when defined, add input rd_idx[5:0] and output rd_data[5:0], registered with 1-cycle latency, returning the active config of pad rd_idx, or 0 when out of range; rd_data SHALL reset to 0.
REQ-032 Without PAD_CFG_READBACK_EN, these ports and the associated logic SHALL be absent.

Structure
REQ-033 Package pad_cfg_pkg SHALL hold the packed pad_cfg_t struct (oe,cs,sl,ie,pu,pd), the bit-position constants, the reset constant PAD_CFG_RST, and the FSM state enum.
REQ-034 SHALL be implemented as a single module with no sub-module; the settle counter is inline.

Verification
REQ-035 Reset: assert rst for 2 cycles -> all bidir_oe=0, all bidir_ie=1, cfg_ready=1, apply_busy=0.
REQ-036 Write pad 3 with 6'b100100 then pulse apply_req, SETTLE_CYCLES=4 -> oe[3] stays 0, ie[3] stays 1, oe[3] rises on the 11th edge after the apply_req edge, apply_done pulses once, and a total of 12 cycles elapse.
REQ-037 Pad 5 active oe=1 and unchanged while pad 6 is changed -> oe[5] never drops; oe[6] drops in OE_OFF before pu[6] changes in UPDATE.
REQ-038 Write with cfg_idx=45 -> cfg_err pulses once and all shadows are unchanged (verified by an apply that shows no output change).
REQ-039 Same-cycle write to pad 0 (6'b000010) and apply_req -> after DONE pu[0]=1; a second apply_req during busy is ignored and only one apply_done occurs.
REQ-040 Assert rst during WAIT1 -> no apply_done pulse, outputs return to reset values at that edge, and the FSM is in IDLE.
